// File: rtl/player_pkg.sv
// Shared codes for the player controller: direction and state encodings,
// sprite IDs, sword visibility codes and the button-priority helper.
package player_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ATTACK   = 2'b01,
    ST_COOLDOWN = 2'b10
  } state_e;

  localparam logic [3:0] SPR_IDLE_A   = 4'b0011;
  localparam logic [3:0] SPR_IDLE_B   = 4'b0010;
  localparam logic [3:0] SPR_ATTACK   = 4'b0100;
  localparam logic [3:0] SWORD_SHOWN  = 4'b0001;
  localparam logic [3:0] SWORD_HIDDEN = 4'b1111;

  localparam logic [1:0] ORIENT_RIGHT = 2'b01;
  localparam logic [1:0] ORIENT_LEFT  = 2'b11;

  // Buttons are {right,left,down,up}; right wins, falling back to cur when none pressed.
  function automatic dir_e prio_dir(input logic [3:0] btn, input dir_e cur);
    if (btn[3])      return DIR_RIGHT;
    else if (btn[2]) return DIR_LEFT;
    else if (btn[1]) return DIR_DOWN;
    else if (btn[0]) return DIR_UP;
    else             return cur;
  endfunction

endpackage

// File: rtl/player_anim_counter.sv
// Idle animation timer: tick-enabled modulo counter that selects sprite
// frame B at the switch count and returns to frame A when it wraps.
module player_anim_counter
  import player_pkg::*;
#(
  parameter int PERIOD = 21,
  parameter int SWITCH = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  output logic [3:0] phase_o
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] LAST_L   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] SWITCH_L = CW'(SWITCH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    phase_q;

  always_comb begin
    cnt_d = (cnt_q == LAST_L) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= SPR_IDLE_A;
    end else if (tick_i) begin
      cnt_q <= cnt_d;
      if (cnt_d == '0)           phase_q <= SPR_IDLE_A;
      else if (cnt_d == SWITCH_L) phase_q <= SPR_IDLE_B;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/player_ctrl_fsm.sv
// Player controller: held-button movement with repeat, sword attack with
// re-arm on button release, post-attack cooldown and idle animation.
module player_ctrl_fsm
  import player_pkg::*;
#(
  parameter int X_BITS          = 4,
  parameter int Y_BITS          = 4,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 15,
  parameter int Y_MIN           = 2,
  parameter int Y_MAX           = 11,
  parameter int START_X         = 1,
  parameter int START_Y         = 3,
  parameter int ATTACK_FRAMES   = 5,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int MOVE_REPEAT     = 4,
  parameter int ANIM_PERIOD     = 21,
  parameter int ANIM_SWITCH     = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [3:0]               dir_in,
  input  logic                     attack_in,
  output logic [X_BITS+Y_BITS-1:0] player_pos,
  output logic [1:0]               player_orientation,
  output logic [1:0]               player_direction,
  output logic [3:0]               player_sprite,
  output logic [X_BITS+Y_BITS-1:0] sword_position,
  output logic [3:0]               sword_visible,
  output logic [1:0]               sword_orientation,
  output logic                     attack_busy,
  output state_e                   dbg_state
);

  localparam int AW = $clog2(ATTACK_FRAMES + 1);
  localparam int CDW = $clog2(COOLDOWN_FRAMES + 2);
  localparam int RW = $clog2(MOVE_REPEAT + 1);
  localparam logic [AW-1:0]  ATK_LOAD = AW'(ATTACK_FRAMES - 1);
  localparam logic [CDW-1:0] CD_LOAD  = CDW'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
  localparam logic [RW-1:0]  RPT_LOAD = RW'(MOVE_REPEAT - 1);
  localparam logic [X_BITS-1:0] XMIN_L = X_BITS'(X_MIN);
  localparam logic [X_BITS-1:0] XMAX_L = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] YMIN_L = Y_BITS'(Y_MIN);
  localparam logic [Y_BITS-1:0] YMAX_L = Y_BITS'(Y_MAX);

  state_e            state_q;
  dir_e              dir_q;
  logic [1:0]        orient_q;
  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;
  logic [X_BITS+Y_BITS-1:0] sword_pos_q;
  logic [3:0]        sword_vis_q;
  dir_e              sword_dir_q;
  logic [AW-1:0]     atk_cnt_q;
  logic [CDW-1:0]    cd_cnt_q;
  logic [RW-1:0]     rpt_cnt_q;
  logic              attack_prev_q;
  logic [3:0]        dir_prev_q;
  logic [3:0]        anim_phase;

  dir_e              mv_dir;
  logic [1:0]        orient_d;
  logic              step_ok;
  logic [X_BITS-1:0] nx;
  logic [Y_BITS-1:0] ny;
  logic              attack_rise;
  logic              new_press;
  logic              do_move;

  // One target tile serves both the move and the sword; bounds are checked
  // before the add/subtract so the fields never wrap.
  always_comb begin
    mv_dir   = prio_dir(dir_in, dir_q);
    orient_d = (mv_dir == DIR_RIGHT) ? ORIENT_RIGHT :
               (mv_dir == DIR_LEFT)  ? ORIENT_LEFT  : orient_q;
    step_ok  = 1'b0;
    nx       = x_q;
    ny       = y_q;
    case (mv_dir)
      DIR_RIGHT: begin step_ok = (x_q < XMAX_L); nx = x_q + 1'b1; end
      DIR_LEFT:  begin step_ok = (x_q > XMIN_L); nx = x_q - 1'b1; end
      DIR_DOWN:  begin step_ok = (y_q < YMAX_L); ny = y_q + 1'b1; end
      default:   begin step_ok = (y_q > YMIN_L); ny = y_q - 1'b1; end
    endcase
    attack_rise = attack_in & ~attack_prev_q;
    new_press   = |(dir_in & ~dir_prev_q);
    do_move     = ((state_q == ST_IDLE) && !attack_rise) || (state_q == ST_COOLDOWN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_RIGHT;
      orient_q      <= ORIENT_RIGHT;
      x_q           <= X_BITS'(START_X);
      y_q           <= Y_BITS'(START_Y);
      sword_pos_q   <= '0;
      sword_vis_q   <= SWORD_HIDDEN;
      sword_dir_q   <= DIR_UP;
      atk_cnt_q     <= '0;
      cd_cnt_q      <= '0;
      rpt_cnt_q     <= '0;
      attack_prev_q <= 1'b0;
      dir_prev_q    <= '0;
    end else if (frame_tick) begin
      attack_prev_q <= attack_in;
      dir_prev_q    <= dir_in;

      if (do_move) begin
        if ((dir_in != '0) && (new_press || (rpt_cnt_q == '0))) begin
          dir_q     <= mv_dir;
          orient_q  <= orient_d;
          rpt_cnt_q <= RPT_LOAD;
          if (step_ok) begin
            x_q <= nx;
            y_q <= ny;
          end
        end else if (dir_in != '0) begin
          rpt_cnt_q <= rpt_cnt_q - 1'b1;
        end else begin
          rpt_cnt_q <= '0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (attack_rise) begin
            state_q     <= ST_ATTACK;
            dir_q       <= mv_dir;
            orient_q    <= orient_d;
            sword_dir_q <= mv_dir;
            atk_cnt_q   <= ATK_LOAD;
            // Off-grid target: the attack still runs, the sword just stays hidden.
            if (step_ok) begin
              sword_pos_q <= {nx, ny};
              sword_vis_q <= SWORD_SHOWN;
            end
          end
        end
        ST_ATTACK: begin
          if (atk_cnt_q == '0) begin
            sword_vis_q <= SWORD_HIDDEN;
            sword_pos_q <= '0;
            if (COOLDOWN_FRAMES == 0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q  <= ST_COOLDOWN;
              cd_cnt_q <= CD_LOAD;
            end
          end else begin
            atk_cnt_q <= atk_cnt_q - 1'b1;
          end
        end
        ST_COOLDOWN: begin
          if (cd_cnt_q == '0) state_q <= ST_IDLE;
          else                cd_cnt_q <= cd_cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  player_anim_counter #(
    .PERIOD (ANIM_PERIOD),
    .SWITCH (ANIM_SWITCH)
  ) u_anim (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (frame_tick),
    .phase_o (anim_phase)
  );

  assign player_pos         = {x_q, y_q};
  assign player_orientation = orient_q;
  assign player_direction   = dir_q;
  assign player_sprite      = (state_q == ST_ATTACK) ? SPR_ATTACK : anim_phase;
  assign sword_position     = sword_pos_q;
  assign sword_visible      = sword_vis_q;
  assign sword_orientation  = sword_dir_q;
  assign attack_busy        = (state_q != ST_IDLE);
  assign dbg_state          = state_q;

endmodule
